poly_bram_rd_arbiter: RTL
=========================

# poly_bram_rd_arbiter

Round-robin arbiter that shares the single read port of the INTT output BRAM between the polynomial subtract stage and the compress/encode stage. Each requester asks for a fixed-length burst from a 7-bit base address. The arbiter owns the BRAM address and enable, returns per-requester read-valid strobes aligned to BRAM read latency, and pulses a per-requester done once the burst's last word is valid. It sits between the INTT result memory and the two consumer stages in the Kyber512 datapath.

## Interface
Parameters:
- ADDR_W, 7: BRAM word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 128: BRAM word width (8 x 16-bit coefficients).
- BURST_LEN, 32: words per burst (one polynomial segment).
- RD_LAT, 1: BRAM read latency in cycles, legal range 1..2.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req0 / req1, in, 1: burst request from sub stage / compress stage; level, held until matching done.
- base0 / base1, in, ADDR_W: burst start address, sampled at grant.
- gnt0 / gnt1, out, 1: high from grant cycle through done cycle of owner's burst.
- bram_ren, out, 1: BRAM read enable.
- bram_rad, out, ADDR_W: BRAM read address.
- bram_rdata, in, DATA_W: BRAM read data.
- rdata, out, DATA_W: bram_rdata, passed through combinationally to both requesters.
- rvalid0 / rvalid1, out, 1: rdata is a valid word for that requester this cycle.
- done0 / done1, out, 1: one-cycle pulse on the cycle of the burst's last rvalid.

## Operation
- States:
  - IDLE: no grant.
  - BURST: issues BURST_LEN addresses.
  - DRAIN: RD_LAT cycles waiting for data.
- IDLE -> BURST when any req is high. The winner is latched in owner and its base is latched in ptr.
- BURST issues one read per cycle: bram_ren=1, bram_rad=ptr, ptr<=ptr+1 (7-bit wrap, 127 -> 0). A 5-bit beat counter counts issued reads.
- BURST -> DRAIN after the BURST_LEN-th read. DRAIN -> IDLE after RD_LAT cycles. done for the owner fires on the final DRAIN cycle, together with the last rvalid.
- Arbitration:
  - Round-robin, using a last-owner register (reset = 1, so requester 0 wins the first tie).
  - Both requesting in IDLE: the requester that is not last-owner wins.
  - A single requester always wins, even if it was last owner.
- A grant is never preempted. Deasserting req mid-burst does not abort it; the burst completes and done still pulses.
- Requesters drop req on the cycle after done. A req still high on the cycle after done is a new request.
- rvalidN = owner==N delayed RD_LAT cycles from bram_ren, implemented as a shift register of (ren, owner). Exactly BURST_LEN rvalid pulses per burst.
- Reset values: gnt0/1=0, bram_ren=0, bram_rad=0, rvalid0/1=0, done0/1=0, state=IDLE, last-owner=1, counter=0.
- rst asserted mid-burst aborts immediately: no done, no further rvalid, and all outputs go to reset values asynchronously.

## Timing
- req high in IDLE at edge k: state=BURST, gntN=1 and first address (base) on bram_rad from edge k+1.
- Addresses base .. base+BURST_LEN-1 are issued on consecutive cycles k+1 .. k+BURST_LEN, with no bubbles.
- rvalid for the address issued at cycle c appears at cycle c+RD_LAT.
- doneN at cycle k+BURST_LEN+RD_LAT; gntN drops the following cycle. Back-to-back grant cost: one IDLE cycle between bursts.
- For RD_LAT=1, BURST_LEN=32: 34 cycles from req edge to done inclusive, 35 cycles per burst including IDLE.
- gnt and done outputs are registered. rdata is combinational from bram_rdata. rvalid is registered.

## Structure
- Shared package (kyber_mem_pkg): ADDR_W, DATA_W and BURST_LEN constants, plus the arbiter state enum {IDLE, BURST, DRAIN}.
- One sub-module, rd_lat_pipe: parameterised RD_LAT-deep shift register carrying {ren, owner}, producing rvalid0/1.
- The arbiter FSM, counter and pointer stay in the top module.

## Test plan
- Single burst: req0=1, base0=0, RD_LAT=1 -> bram_rad 0..31 on cycles 1..32; rvalid0 on cycles 2..33; done0 at cycle 33; rvalid1 never asserts.
- Tie: req0=req1=1 from reset -> requester 0 granted first. Requester 1 is granted on the cycle after IDLE following done0 (cycle 35 for RD_LAT=1). Repeated ties alternate owners.
- Wrap: req1=1, base1=100 -> addresses 100..127 then 0..3; exactly 32 rvalid1 pulses, then done1.
- req0 deasserted at beat 10 -> burst still issues 32 reads and done0 pulses. req1 raised mid-burst waits and gets no grant until after done0.
- rst asserted at beat 15 for one cycle -> all outputs 0 immediately, no done. A new req0 afterwards restarts from base0 with a full 32-beat burst.
- RD_LAT=2 build -> rvalid lags bram_ren by 2 cycles; done at cycle 34 from req edge; rvalid count 32.

Source files
------------

// File: rtl/kyber_mem_pkg.sv
// Shared constants and types for the Kyber512 INTT-output memory path.
//   ADDR_W    : BRAM word-address width (addresses wrap modulo 2^ADDR_W)
//   DATA_W    : BRAM word width (8 x 16-bit coefficients)
//   BURST_LEN : words per read burst (one polynomial segment)
//   arb_state_e : read-port arbiter states
package kyber_mem_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned BURST_LEN = 32;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } arb_state_e;

endpackage

// File: rtl/rd_lat_pipe.sv
// Delays the per-requester read-valid by the BRAM read latency.
//   clk, rst         : clock, asynchronous active-high reset
//   ren, owner       : read enable issued this cycle and the requester it belongs to
//   rvalid0, rvalid1 : registered valid strobes, RD_LAT cycles after ren
module rd_lat_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ren,
  input  logic owner,
  output logic rvalid0,
  output logic rvalid1
);

  // {ren, owner} is carried pre-decoded as one valid bit per requester so
  // the outputs come straight from flops.
  logic [RD_LAT-1:0] v0_q;
  logic [RD_LAT-1:0] v1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= '0;
      v1_q <= '0;
    end else begin
      v0_q[0] <= ren & ~owner;
      v1_q[0] <= ren & owner;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        v0_q[i] <= v0_q[i-1];
        v1_q[i] <= v1_q[i-1];
      end
    end
  end

  assign rvalid0 = v0_q[RD_LAT-1];
  assign rvalid1 = v1_q[RD_LAT-1];

endmodule

// File: rtl/poly_bram_rd_arbiter.sv
// Round-robin arbiter sharing the INTT output BRAM read port between the
// polynomial subtract stage (requester 0) and compress/encode stage (1).
//   clk, rst             : clock, asynchronous active-high reset
//   req0/1, base0/1      : level burst request and start address (sampled at grant)
//   gnt0/1               : owner indication, grant cycle through done cycle
//   bram_ren, bram_rad   : BRAM read enable / address
//   bram_rdata, rdata    : BRAM read data, passed through to both requesters
//   rvalid0/1            : rdata valid for that requester this cycle
//   done0/1              : one-cycle pulse with the burst's last rvalid
module poly_bram_rd_arbiter #(
  parameter int unsigned ADDR_W    = kyber_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W    = kyber_mem_pkg::DATA_W,
  parameter int unsigned BURST_LEN = kyber_mem_pkg::BURST_LEN,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              bram_ren,
  output logic [ADDR_W-1:0] bram_rad,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              done0,
  output logic              done1
);
  import kyber_mem_pkg::*;

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] DONE_AT    = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              owner_q, owner_d;  // current owner, doubles as last owner
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              done_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    done_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // Tie goes to whoever did not own last; a lone requester always wins.
          owner_d = (req0 & req1) ? ~owner_q : req1;
          ptr_d   = owner_d ? base1 : base0;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (cnt_q == LAST_BEAT) begin
          cnt_d     = '0;
          state_d   = DRAIN;
          // Done is registered, so it is set one cycle ahead of the last
          // DRAIN cycle; with a single-cycle drain that is this edge.
          done_fire = (RD_LAT == 1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          done_fire = (cnt_q == DONE_AT);
        end
      end
      default: state_d = IDLE;
    endcase
    gnt0_d  = (state_d != IDLE) & ~owner_d;
    gnt1_d  = (state_d != IDLE) & owner_d;
    done0_d = done_fire & ~owner_q;
    done1_d = done_fire & owner_q;
  end

  assign bram_ren = (state_q == BURST);
  assign bram_rad = ptr_q;
  assign rdata    = bram_rdata;
  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;

  rd_lat_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_lat_pipe (
    .clk    (clk),
    .rst    (rst),
    .ren    (bram_ren),
    .owner  (owner_q),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1)
  );

endmodule
